mtx_sched: RTL

//  Job scheduler for the Matrix Sub-System. Sits between the job source and the NUM_CH MAPU channels.

---
 rtl/mtx_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mtx_sched.sv
// mtx_sched: round-robin job scheduler for the Matrix Sub-System.
// Accepts descriptors over valid/ready, dispatches each to a free MAPU channel,
// tracks per-channel busy state and returns completions (with job ID) one at a time.
module mtx_sched #(
    parameter int NUM_CH     = 32,
    parameter int DESC_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      test_mode_en,
    input  logic                      ctl_en,
    output logic                      sts_idle,
    output logic [NUM_CH-1:0]         sts_busy,
    output logic                      err_spurious,
    input  logic                      job_vld,
    output logic                      job_rdy,
    input  logic [DESC_WIDTH-1:0]     job_desc,
    input  logic [ID_WIDTH-1:0]       job_id,
    output logic [NUM_CH-1:0]         ch_start_vld,
    input  logic [NUM_CH-1:0]         ch_start_rdy,
    output logic [DESC_WIDTH-1:0]     ch_desc,
    input  logic [NUM_CH-1:0]         ch_done,
    output logic                      cpl_vld,
    input  logic                      cpl_rdy,
    output logic [$clog2(NUM_CH)-1:0] cpl_ch,
    output logic [ID_WIDTH-1:0]       cpl_id
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic                    sts_idle_q, sts_idle_d;
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]       busy_q, busy_d;
    logic [NUM_CH-1:0]       pend_q, pend_d;
    logic                    hold_q, hold_d;
    logic [CH_W-1:0]         sel_q, sel_d;
    logic [DESC_WIDTH-1:0]   desc_q, desc_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ID_WIDTH-1:0]     id_tbl_q [NUM_CH];
    logic [ID_WIDTH-1:0]     id_tbl_d [NUM_CH];
    logic                    err_q, err_d;
    logic                    cpl_lock_q, cpl_lock_d;
    logic [CH_W-1:0]         cpl_sel_q, cpl_sel_d;

    logic [NUM_CH-1:0]       start_vld_w;
    logic [NUM_CH-1:0]       elig;
    logic [NUM_CH-1:0]       free_w;
    logic [CH_W-1:0]         pick;
    logic                    found;
    logic [CH_W-1:0]         low_pend;
    logic                    low_found;
    logic [CH_W-1:0]         cpl_ch_w;
    logic                    cpl_any;
    logic                    acc;
    logic                    start_hs;
    logic                    cpl_hs;

    // Free-channel mask and round-robin search starting at rr_ptr
    always_comb begin
        int unsigned idx;
        start_vld_w = '0;
        if (hold_q) start_vld_w[sel_q] = 1'b1;
        elig   = test_mode_en ? NUM_CH'(1) : '1;
        free_w = ~busy_q & ~pend_q & ~start_vld_w & elig;
        pick   = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx -= NUM_CH;
            if (!found && free_w[CH_W'(idx)]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    // Lowest pending completion; held while a completion is being offered
    always_comb begin
        low_pend  = '0;
        low_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!low_found && pend_q[CH_W'(k)]) begin
                low_found = 1'b1;
                low_pend  = CH_W'(k);
            end
        end
        cpl_any  = |pend_q;
        cpl_ch_w = cpl_lock_q ? cpl_sel_q : low_pend;
    end

    assign job_rdy      = (state_q == ST_RUN) && !hold_q && found;
    assign ch_start_vld = start_vld_w;
    assign ch_desc      = desc_q;
    assign sts_busy     = busy_q;
    assign sts_idle     = sts_idle_q;
    assign err_spurious = err_q;
    assign cpl_vld      = cpl_any;
    assign cpl_ch       = cpl_ch_w;
    assign cpl_id       = id_tbl_q[cpl_ch_w];

    // Next-state: dispatch, start handshake, completion tracking and control FSM
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        sel_d      = sel_q;
        desc_d     = desc_q;
        id_d       = id_q;
        id_tbl_d   = id_tbl_q;

        acc      = job_vld && job_rdy;
        start_hs = hold_q && ch_start_rdy[sel_q];
        cpl_hs   = cpl_any && cpl_rdy;

        // Completions only count on busy channels; anything else is flagged
        busy_d = busy_q & ~ch_done;
        pend_d = pend_q | (ch_done & busy_q);
        err_d  = err_q | (|(ch_done & ~busy_q));
        if (cpl_hs) pend_d[cpl_ch_w] = 1'b0;

        if (acc) begin
            hold_d = 1'b1;
            sel_d  = pick;
            desc_d = job_desc;
            id_d   = job_id;
        end

        if (start_hs) begin
            busy_d[sel_q]   = 1'b1;
            id_tbl_d[sel_q] = id_q;
            hold_d          = 1'b0;
            rr_ptr_d        = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + CH_W'(1);
        end

        // Freeze the offered index until it is consumed so a lower one cannot preempt
        cpl_lock_d = cpl_any && !cpl_rdy;
        cpl_sel_d  = cpl_ch_w;

        case (state_q)
            ST_IDLE:  if (ctl_en) state_d = ST_RUN;
            ST_RUN:   if (!ctl_en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (ctl_en)
                    state_d = ST_RUN;
                else if ((busy_q == '0) && (pend_q == '0) && !hold_q)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        sts_idle_d = (state_d == ST_IDLE);
    end

    // State registers with asynchronous reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            sts_idle_q <= 1'b1;
            rr_ptr_q   <= '0;
            busy_q     <= '0;
            pend_q     <= '0;
            hold_q     <= 1'b0;
            sel_q      <= '0;
            desc_q     <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            cpl_lock_q <= 1'b0;
            cpl_sel_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) id_tbl_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sts_idle_q <= sts_idle_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            sel_q      <= sel_d;
            desc_q     <= desc_d;
            id_q       <= id_d;
            err_q      <= err_d;
            cpl_lock_q <= cpl_lock_d;
            cpl_sel_q  <= cpl_sel_d;
            id_tbl_q   <= id_tbl_d;
        end
    end

endmodule
